ucode_loader: RTL and testbench
===============================

# ucode_loader

Loads the 512×36 microcode store that the 65C02 control sequencer reads each cycle. It receives a byte stream from a host link, assembles 36-bit control words, and writes them into the microcode RAM port. It holds the CPU core in reset until a complete, checksum-verified image has been written. It sits between the host UART/debug bridge and the write port of the microcode RAM.

## Interface
Parameters:
- `AW`, 9: microcode RAM address width; maximum depth is 2^AW words.
- `DW`, 36: control word width; fixed at 5 bytes per word.

Ports:
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  asynchronous reset, active-low.
- `in_valid`  in  1  host byte available.
- `in_data`  in  8  host byte.
- `in_ready`  out  1  block accepts the byte this cycle; a byte transfers when `in_valid && in_ready`.
- `mem_we`  out  1  microcode RAM write strobe, one cycle per word.
- `mem_addr`  out  AW  RAM write address.
- `mem_wdata`  out  DW  RAM write data.
- `core_hold`  out  1  active-high reset to the CPU core and sequencer.
- `done`  out  1  last image loaded and verified.
- `error`  out  1  last load aborted; sticky until the next header.

## Operation
Frame format, in byte order:
- header 0xA5
- `cnt_lo`, `cnt_hi`: word count N, little-endian, valid range 1..2^AW
- N×5 data bytes, little-endian per word; byte 4 carries bits [35:32] in its low nibble, and its high nibble must be 0
- checksum byte `C`

Checksum rule:
- `sum` is an 8-bit modular sum of `cnt_lo`, `cnt_hi`, every data byte, and `C`.
- `sum` must equal 0x00.

FSM states: IDLE, CNT_LO, CNT_HI, DATA, WRITE, CSUM, DONE.
- **IDLE:** 0xA5 goes to CNT_LO. The transition clears `error` and `done`, sets `core_hold`=1, and clears `sum`, the address, and the byte index. Any other byte is consumed and ignored.
- **CNT_LO / CNT_HI:** capture N.
  - If N == 0 or N > 2^AW after CNT_HI, set `error` and return to IDLE.
  - Otherwise go to DATA.
- **DATA:** shift bytes into the word register, with byte index counting 0..4.
  - On byte 4 with a nonzero high nibble: set `error`, go to IDLE, and perform no write.
  - Otherwise go to WRITE.
- **WRITE:** one cycle.
  - `mem_we`=1, with `mem_addr` = current address and `mem_wdata` = assembled word.
  - `in_ready`=0.
  - Address increments; the remaining count decrements.
  - Go to DATA if words remain, else go to CSUM.
- **CSUM:** accept one byte.
  - If `sum` is 0: go to DONE with `done`=1 and `core_hold`=0.
  - Otherwise: go to IDLE with `error`=1 and `core_hold` remaining 1.
- **DONE:** behaves as IDLE for header detection. A 0xA5 restarts a load and re-asserts `core_hold`. Other bytes are ignored.

Additional rules:
- A failed load leaves partially written RAM. `core_hold` stays 1 until a good load completes.
- Address arithmetic is AW+1 bits internally, so N = 2^AW writes addresses 0..2^AW−1 with no wrap. `mem_addr` never wraps to 0 within a frame.

## Timing
Reset values:
- `in_ready`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_hold`=1, `done`=0, `error`=0
- state = IDLE

Cycle-level behaviour:
- `in_ready` is 1 in every state except WRITE, and is a registered function of state.
- `mem_we` asserts exactly one cycle after the 5th byte of a word is accepted.
- `mem_addr` and `mem_wdata` are stable during the `mem_we` cycle. `mem_wdata` holds its value afterwards.
- Minimum frame time is 3 + 6N + 1 cycles with `in_valid` held high.
- `done`, `core_hold`, and `error` update in the cycle after the checksum byte is accepted.
- `rst_n` low mid-frame: all outputs return to reset values immediately and asynchronously, and no further `mem_we` is issued. Contents already in RAM are not cleared.
- `in_valid` may drop at any point; the FSM holds state.
- `in_data` is ignored whenever `in_valid`=0 or `in_ready`=0.

## Test plan
- **1-word frame:** A5 01 00 78 56 34 12 0F, with C chosen so `sum`=0 → one `mem_we`, `mem_addr`=0, `mem_wdata`=36'hF12345678; `done`=1 and `core_hold`=0 one cycle after the checksum byte.
- **Same frame with C+1** → write still occurs; `error`=1, `done`=0, `core_hold`=1.
- **Count faults:** A5 00 00 → `error`=1 after `cnt_hi`, no writes. A5 01 02 (N=513) → same response.
- **Nibble fault:** word byte 4 = 0x1F → no `mem_we` for that word, `error`=1. A following non-0xA5 byte is ignored.
- **Full 512-word image with continuous `in_valid`:**
  - `in_ready` drops for exactly one cycle per word.
  - Addresses run 0..511 with no skips or repeats.
  - `done`=1.
  - A second frame re-asserts `core_hold` on its header byte.
- **Reset mid-load:** `rst_n` pulsed low after word 3's 2nd byte → `mem_we` never fires for word 3. A fresh frame afterwards loads from address 0.

Source files
------------

// File: rtl/ucode_loader.sv
// Assembles a host byte stream into 36-bit words, writes them to microcode RAM, and holds the core until a checksummed image lands.
// One accepted byte per cycle, plus one extra cycle per word for the RAM write; in_ready is low only during that write cycle.
module ucode_loader #(
    parameter int AW = 9,
    parameter int DW = 36
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          core_hold,
    output logic          done,
    output logic          error
);
    localparam int CW = AW + 1;
    localparam logic [16:0] MAX_N = 17'(1) << AW;

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_WRITE, S_CSUM, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_lo_q, cnt_lo_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [CW-1:0] addr_q, addr_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   word_q, word_d;
    logic [7:0]    sum_q, sum_d;
    logic          in_ready_q, in_ready_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          core_hold_q, core_hold_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          acc;
    logic [7:0]    sum_next;
    logic [15:0]   n_word;

    assign acc      = in_valid && in_ready_q;
    assign sum_next = sum_q + in_data;
    assign n_word   = {in_data, cnt_lo_q};

    always_comb begin
        state_d     = state_q;
        cnt_lo_d    = cnt_lo_q;
        rem_d       = rem_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        word_d      = word_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        core_hold_d = core_hold_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (acc && in_data == 8'hA5) begin
                    state_d     = S_CNT_LO;
                    error_d     = 1'b0;
                    done_d      = 1'b0;
                    core_hold_d = 1'b1;
                    sum_d       = 8'h00;
                    addr_d      = '0;
                    idx_d       = 3'd0;
                end
            end
            S_CNT_LO: begin
                if (acc) begin
                    cnt_lo_d = in_data;
                    sum_d    = sum_next;
                    state_d  = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (acc) begin
                    sum_d = sum_next;
                    if (n_word == 16'd0 || {1'b0, n_word} > MAX_N) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rem_d   = n_word[CW-1:0];
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (acc) begin
                    sum_d = sum_next;
                    if (idx_q == 3'd4) begin
                        idx_d = 3'd0;
                        // Byte 4 only carries bits [35:32]; a set high nibble means a corrupt stream.
                        if (in_data[7:4] != 4'h0) begin
                            error_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = addr_q[AW-1:0];
                            mem_wdata_d = DW'({in_data[3:0], word_q});
                            state_d     = S_WRITE;
                        end
                    end else begin
                        word_d[{idx_q[1:0], 3'b000} +: 8] = in_data;
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + CW'(1);
                rem_d   = rem_q - CW'(1);
                state_d = (rem_q == CW'(1)) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (acc) begin
                    if (sum_next == 8'h00) begin
                        done_d      = 1'b1;
                        core_hold_d = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d != S_WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_lo_q    <= 8'h00;
            rem_q       <= '0;
            addr_q      <= '0;
            idx_q       <= 3'd0;
            word_q      <= 32'h0;
            sum_q       <= 8'h00;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_lo_q    <= cnt_lo_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_hold_q <= core_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_hold = core_hold_q;
    assign done      = done_q;
    assign error     = error_q;
endmodule

// File: tb/tb_ucode_loader.sv
// Bench for ucode_loader: random and directed frames checked against a frame-level reference model.
module tb_ucode_loader;
    localparam int AW = 9;
    localparam int DW = 36;

    typedef logic [7:0] byte_t;
    typedef byte_t bq_t[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          core_hold;
    logic          done;
    logic          error;

    ucode_loader #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_hold(core_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ready_low = 0;
    logic [AW+DW-1:0] got_q[$];
    logic [AW+DW-1:0] exp_q[$];
    bit m_done, m_err, m_hold;

    always @(negedge clk) begin
        if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});
        if (in_ready === 1'b0) ready_low++;
    end

    // Reference: parse one frame starting with its header and derive writes and final status.
    task automatic model_frame(input bq_t fr);
        int n;
        byte_t s;
        logic [DW-1:0] w;
        exp_q.delete();
        if (fr.size() == 0 || fr[0] != 8'hA5) return;
        m_err = 0; m_done = 0; m_hold = 1;
        if (fr.size() < 3) return;
        n = int'(fr[1]) + 256 * int'(fr[2]);
        if (n == 0 || n > (1 << AW)) begin m_err = 1; return; end
        s = byte_t'(fr[1] + fr[2]);
        for (int k = 0; k < n; k++) begin
            if (fr.size() < 3 + 5*k + 5) return;
            if (fr[3+5*k+4][7:4] != 4'h0) begin m_err = 1; return; end
            w = {fr[3+5*k+4][3:0], fr[3+5*k+3], fr[3+5*k+2], fr[3+5*k+1], fr[3+5*k]};
            for (int j = 0; j < 5; j++) s = byte_t'(s + fr[3+5*k+j]);
            exp_q.push_back({AW'(k), w});
        end
        if (fr.size() < 3 + 5*n + 1) return;
        if (byte_t'(s + fr[3+5*n]) == 8'h00) begin m_done = 1; m_hold = 0; end
        else m_err = 1;
    endtask

    function automatic bq_t build(input int n, input bit bad_csum, input int bad_word);
        bq_t fr;
        byte_t s, b;
        fr.push_back(8'hA5);
        fr.push_back(byte_t'(n & 255));
        fr.push_back(byte_t'(n >> 8));
        s = byte_t'(fr[1] + fr[2]);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 5; j++) begin
                b = byte_t'($urandom_range(0, 255));
                if (j == 4) b = (k == bad_word) ? {4'(1 + $urandom_range(0, 14)), b[3:0]} : {4'h0, b[3:0]};
                fr.push_back(b);
                s = byte_t'(s + b);
                if (j == 4 && k == bad_word) return fr;
            end
        end
        fr.push_back(byte_t'(8'h00 - s + (bad_csum ? 1 : 0)));
        return fr;
    endfunction

    task automatic send_byte(input byte_t b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin in_valid = 1'b0; @(negedge clk); cyc++; end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin @(negedge clk); cyc++; t++; end
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk); cyc++;
    endtask

    task automatic run_frame(input bq_t fr, input int maxgap);
        got_q.delete();
        foreach (fr[i]) send_byte(fr[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        model_frame(fr);
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL reset_core_hold: got %b want 1", core_hold); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    endtask

    task automatic test_one_word(input byte_t c, input string nm);
        bq_t fr;
        logic [AW+DW-1:0] want;
        fr = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0F};
        fr.push_back(c);
        got_q.delete();
        for (int i = 0; i < fr.size(); i++) send_byte(fr[i], 0);
        in_valid = 1'b0;
        model_frame(fr);
        // Status must already reflect the checksum one cycle after it was accepted.
        checks++; if (done !== m_done) begin errors++; $display("FAIL %s_done: got %b want %b", nm, done, m_done); end
        checks++; if (core_hold !== m_hold) begin errors++; $display("FAIL %s_hold: got %b want %b", nm, core_hold, m_hold); end
        checks++; if (error !== m_err) begin errors++; $display("FAIL %s_error: got %b want %b", nm, error, m_err); end
        repeat (3) @(negedge clk);
        want = {9'd0, 36'hF12345678};
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL %s_writes: got %0d want 1", nm, got_q.size()); end
        else begin
            checks++; if (got_q[0] !== want) begin errors++; $display("FAIL %s_word: got %h want %h", nm, got_q[0], want); end
        end
    endtask

    task automatic test_count_faults();
        bq_t fr;
        for (int v = 0; v < 2; v++) begin
            fr = (v == 0) ? '{8'hA5, 8'h00, 8'h00} : '{8'hA5, 8'h01, 8'h02};
            got_q.delete();
            for (int i = 0; i < 3; i++) send_byte(fr[i], 0);
            in_valid = 1'b0;
            model_frame(fr);
            checks++; if (error !== m_err) begin errors++; $display("FAIL cnt%0d_error: got %b want %b", v, error, m_err); end
            repeat (3) @(negedge clk);
            checks++; if (got_q.size() != 0) begin errors++; $display("FAIL cnt%0d_writes: got %0d want 0", v, got_q.size()); end
            checks++; if (core_hold !== m_hold) begin errors++; $display("FAIL cnt%0d_hold: got %b want %b", v, core_hold, m_hold); end
            checks++; if (done !== m_done) begin errors++; $display("FAIL cnt%0d_done: got %b want %b", v, done, m_done); end
        end
    endtask

    task automatic test_nibble();
        bq_t fr;
        fr = build(2, 1'b0, 1);
        run_frame(fr, 0);
        send_byte(8'h3C, 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL nib_writes: got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL nib_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL nib_error: got %b want 1", error); end
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL nib_hold: got %b want 1", core_hold); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nib_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_random();
        bq_t fr;
        int n, bw;
        bit bc;
        for (int it = 0; it < 10; it++) begin
            n  = $urandom_range(1, 6);
            bc = ($urandom_range(0, 2) == 0);
            bw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            fr = build(n, bc, bw);
            run_frame(fr, 2);
            checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_writes: got %0d want %0d", it, got_q.size(), exp_q.size()); end
            else foreach (exp_q[i]) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_word%0d: got %h want %h", it, i, got_q[i], exp_q[i]); end
            end
            checks++; if (done !== m_done) begin errors++; $display("FAIL rnd%0d_done: got %b want %b", it, done, m_done); end
            checks++; if (error !== m_err) begin errors++; $display("FAIL rnd%0d_error: got %b want %b", it, error, m_err); end
            checks++; if (core_hold !== m_hold) begin errors++; $display("FAIL rnd%0d_hold: got %b want %b", it, core_hold, m_hold); end
        end
    endtask

    task automatic test_full_image();
        bq_t fr;
        int bad;
        fr = build(1 << AW, 1'b0, -1);
        ready_low = 0;
        cyc = 0;
        run_frame(fr, 0);
        checks++; if (cyc != 3 + 6 * (1 << AW) + 1) begin errors++; $display("FAIL full_cycles: got %0d want %0d", cyc, 3 + 6 * (1 << AW) + 1); end
        checks++; if (ready_low != (1 << AW)) begin errors++; $display("FAIL full_ready_low: got %0d want %0d", ready_low, 1 << AW); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL full_writes: got %0d want %0d", got_q.size(), exp_q.size()); end
        else begin
            bad = 0;
            foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL full_words: got %0d wrong entries want 0", bad); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %b want 1", done); end
        checks++; if (core_hold !== 1'b0) begin errors++; $display("FAIL full_hold: got %b want 0", core_hold); end
        fr = build(1, 1'b0, -1);
        send_byte(fr[0], 0);
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL rehdr_hold: got %b want 1", core_hold); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rehdr_done: got %b want 0", done); end
        for (int i = 1; i < fr.size(); i++) send_byte(fr[i], 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bq_t fr, part;
        fr = build(4, 1'b0, -1);
        part = fr[0:14];
        got_q.delete();
        foreach (part[i]) send_byte(part[i], 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0)
            begin errors++; $display("FAIL midrst_dp: got rdy=%b we=%b addr=%h wd=%h want 1 0 0 0", in_ready, mem_we, mem_addr, mem_wdata); end
        checks++; if (core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0)
            begin errors++; $display("FAIL midrst_status: got hold=%b done=%b err=%b want 1 0 0", core_hold, done, error); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        model_frame(part);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_writes: got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        fr = build(3, 1'b0, -1);
        run_frame(fr, 1);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL reload_writes: got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reload_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL reload_done: got %b want 1", done); end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_one_word(8'hDC, "good1");
        test_one_word(8'hDD, "badcs");
        test_count_faults();
        test_nibble();
        test_random();
        test_full_image();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
